// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchroniser, counter-based debounce FSM,
// registered debounced level plus press/release/long-press one-cycle pulses.
module button_conditioner #(
    parameter int NUM_BUTTONS       = 2,
    parameter bit ACTIVE_LOW_IN     = 1'b1,
    parameter int DEBOUNCE_CYCLES   = 240000,
    parameter int LONG_PRESS_CYCLES = 12000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_long
);

    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam bit LONG_EN = (LONG_PRESS_CYCLES > 0);
    localparam int HW      = LONG_EN ? $clog2(LONG_PRESS_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_LAST = LONG_EN ? HW'(LONG_PRESS_CYCLES - 1) : '0;
    localparam logic [HW-1:0] HCNT_MAX  = LONG_EN ? HW'(LONG_PRESS_CYCLES) : '0;

    // Pad level of a released button; the synchroniser resets to it so reset
    // never looks like a press.
    localparam logic [NUM_BUTTONS-1:0] INACTIVE = {NUM_BUTTONS{ACTIVE_LOW_IN}};

    typedef enum logic [1:0] {
        RELEASED,
        CONFIRM_PRESS,
        PRESSED,
        CONFIRM_RELEASE
    } state_t;

    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    logic [NUM_BUTTONS-1:0] w_pressed;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source; blocking here would collapse the 2-flop chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= INACTIVE;
            r_sync2 <= INACTIVE;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = r_sync2 ^ INACTIVE;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
        state_t          r_state;
        logic [DW-1:0]   r_dcnt;
        logic [HW-1:0]   r_hcnt;
        logic            r_level;
        logic            r_press;
        logic            r_release;
        logic            r_long;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state   <= RELEASED;
                r_dcnt    <= '0;
                r_hcnt    <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
                case (r_state)
                    RELEASED: begin
                        if (w_pressed[g]) begin
                            r_state <= CONFIRM_PRESS;
                            r_dcnt  <= '0;
                        end
                    end
                    CONFIRM_PRESS: begin
                        if (!w_pressed[g]) begin
                            r_state <= RELEASED;
                        end else if (r_dcnt == DCNT_LAST) begin
                            r_state <= PRESSED;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                            r_hcnt  <= '0;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!w_pressed[g]) begin
                            r_state <= CONFIRM_RELEASE;
                            r_dcnt  <= '0;
                        end else begin
                            // Saturating one past the trigger value makes the long pulse one-shot.
                            if (r_hcnt != HCNT_MAX) r_hcnt <= r_hcnt + 1'b1;
                            if (LONG_EN && (r_hcnt == HCNT_LAST)) r_long <= 1'b1;
                        end
                    end
                    CONFIRM_RELEASE: begin
                        if (w_pressed[g]) begin
                            r_state <= PRESSED;
                        end else if (r_dcnt == DCNT_LAST) begin
                            r_state   <= RELEASED;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                    default: r_state <= RELEASED;
                endcase
            end
        end

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;
        assign btn_long[g]    = r_long;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (N=2, active-low pads, debounce 4, long 16).
module tb_button_conditioner;

    localparam int N = 2;
    localparam int D = 4;
    localparam int L = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
        logic [N-1:0] level;
    } exp_t;

    exp_t exp_q[$];

    button_conditioner #(
        .NUM_BUTTONS      (N),
        .ACTIVE_LOW_IN    (1'b1),
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    // Edge counter: value seen at a negedge is the number of the last posedge.
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input logic [N-1:0] p, input logic [N-1:0] r,
                        input logic [N-1:0] l, input logic [N-1:0] lv);
        exp_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.lng   = l;
        e.level = lv;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any pulse on the outputs must match the next expected event.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && ((btn_press | btn_release | btn_long) != '0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {btn_press, btn_release, btn_long}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_edge", cyc, e.cyc);
                check("press",   btn_press,   e.press);
                check("release", btn_release, e.rel);
                check("long",    btn_long,    e.lng);
                check("level",   btn_level,   e.level);
            end
            check("press_release_excl", btn_press & btn_release, 32'd0);
        end
    end

    initial begin
        int s;
        reset_n = 1'b0;
        btn_raw = 2'b00;
        idle(3);
        check("rst_level",   btn_level,   32'd0);
        check("rst_press",   btn_press,   32'd0);
        check("rst_release", btn_release, 32'd0);
        check("rst_long",    btn_long,    32'd0);

        // Both held pressed through reset: press only after full latency.
        reset_n = 1'b1;
        s = cyc;
        push(s + 7,  2'b11, 2'b00, 2'b00, 2'b11);
        push(s + 23, 2'b00, 2'b00, 2'b11, 2'b11);
        idle(30);
        s = cyc;
        btn_raw = 2'b11;
        push(s + 7, 2'b00, 2'b11, 2'b00, 2'b00);
        idle(12);

        // ch0 clean press, held 40 cycles, then released.
        s = cyc;
        btn_raw = 2'b10;
        push(s + 7,  2'b01, 2'b00, 2'b00, 2'b01);
        push(s + 23, 2'b00, 2'b00, 2'b01, 2'b01);
        idle(40);
        s = cyc;
        btn_raw = 2'b11;
        push(s + 7, 2'b00, 2'b01, 2'b00, 2'b00);
        idle(12);

        // ch0 3-cycle glitch: nothing accepted.
        btn_raw = 2'b10;
        idle(3);
        btn_raw = 2'b11;
        idle(12);
        check("glitch_level", btn_level, 32'd0);

        // ch0 pressed, 2-cycle release bounce: hold count pauses 3 edges.
        s = cyc;
        btn_raw = 2'b10;
        push(s + 7,  2'b01, 2'b00, 2'b00, 2'b01);
        push(s + 26, 2'b00, 2'b00, 2'b01, 2'b01);
        idle(10);
        btn_raw = 2'b11;
        idle(2);
        btn_raw = 2'b10;
        idle(20);
        check("bounce_level", btn_level, 32'd1);
        s = cyc;
        btn_raw = 2'b11;
        push(s + 7, 2'b00, 2'b01, 2'b00, 2'b00);
        idle(12);

        // ch1 pressed, ch0 mid-confirm when reset hits asynchronously.
        s = cyc;
        btn_raw = 2'b01;
        push(s + 7,  2'b10, 2'b00, 2'b00, 2'b10);
        push(s + 23, 2'b00, 2'b00, 2'b10, 2'b10);
        idle(30);
        btn_raw = 2'b00;
        idle(4);
        check("pre_reset_level", btn_level, 32'd2);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_level",   btn_level,   32'd0);
        check("async_rst_press",   btn_press,   32'd0);
        check("async_rst_release", btn_release, 32'd0);
        check("async_rst_long",    btn_long,    32'd0);
        idle(2);
        reset_n = 1'b1;
        s = cyc;
        push(s + 7,  2'b11, 2'b00, 2'b00, 2'b11);
        push(s + 23, 2'b00, 2'b00, 2'b11, 2'b11);
        idle(30);
        s = cyc;
        btn_raw = 2'b11;
        push(s + 7, 2'b00, 2'b11, 2'b00, 2'b00);
        idle(12);

        check("events_outstanding", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
